// File: rtl/uart_hamming_pkg.sv
// Shared types and Hamming(7,4) helpers for the UART receive endpoint.
package uart_hamming_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D0_POS = 2;
    localparam int P4_POS = 3;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;

    // Returns {s4,s2,s1}; a non-zero value is the 1-based position of the bad bit.
    function automatic logic [2:0] hamming74_syndrome(input logic [6:0] c);
        logic s1, s2, s4;
        s1 = c[P1_POS] ^ c[D0_POS] ^ c[D1_POS] ^ c[D3_POS];
        s2 = c[P2_POS] ^ c[D0_POS] ^ c[D2_POS] ^ c[D3_POS];
        s4 = c[P4_POS] ^ c[D1_POS] ^ c[D2_POS] ^ c[D3_POS];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Circular nibble FIFO; pointers carry one extra wrap bit to tell full from empty.
module nibble_fifo #(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [3:0]  din,
    output logic [3:0]  dout,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]  mem_q [FIFO_DEPTH];
    logic        do_push, do_pop;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_hamming_rx_fifo.sv
// UART receiver + Hamming(7,4) corrector feeding a nibble FIFO.
// Optional extended Hamming(8,4) checking when UART_RX_SECDED_EN is defined.
module uart_hamming_rx_fifo
    import uart_hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          rx,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [3:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_corrected,
    output logic [2:0]                    err_syndrome,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [1:0]                    state_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;

    logic            dec_vld_q, dec_vld_d;
    logic [3:0]      dec_data_q, dec_data_d;
    logic            dec_corr_q, dec_corr_d;
    logic [2:0]      dec_syn_q, dec_syn_d;
    logic            frame_err_q, frame_err_d;

    logic            err_corr_q, overflow_q;
    logic [2:0]      err_syn_q;

    logic [2:0]      syn;
    logic [6:0]      fixed;
    logic            dec_bad, dec_corr;
    logic            fifo_full, fifo_empty, pop;

    always_comb begin
        syn   = hamming74_syndrome(shreg_q[6:0]);
        fixed = shreg_q[6:0];
        if (syn != 3'd0) fixed = shreg_q[6:0] ^ (7'd1 << (syn - 3'd1));
    end

`ifdef UART_RX_SECDED_EN
    logic par_odd;
    assign par_odd  = ^shreg_q;
    // Even overall parity with a non-zero syndrome can only be a double error.
    assign dec_bad  = (syn != 3'd0) && !par_odd;
    assign dec_corr = (syn != 3'd0) || par_odd;
`else
    assign dec_bad  = shreg_q[7];
    assign dec_corr = (syn != 3'd0);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        dec_vld_d   = 1'b0;
        dec_data_d  = dec_data_q;
        dec_corr_d  = dec_corr_q;
        dec_syn_d   = dec_syn_q;
        frame_err_d = 1'b0;
        if (!ena) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (rx_prev_q && !rx_sync_q) state_d = ST_START;
                end
                ST_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shreg_d = {rx_sync_q, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        if (!rx_sync_q || dec_bad) begin
                            frame_err_d = 1'b1;
                        end else begin
                            dec_vld_d  = 1'b1;
                            dec_data_d = {fixed[D3_POS], fixed[D2_POS], fixed[D1_POS], fixed[D0_POS]};
                            dec_corr_d = dec_corr;
                            dec_syn_d  = syn;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            dec_vld_q   <= 1'b0;
            dec_data_q  <= '0;
            dec_corr_q  <= 1'b0;
            dec_syn_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            dec_vld_q   <= dec_vld_d;
            dec_data_q  <= dec_data_d;
            dec_corr_q  <= dec_corr_d;
            dec_syn_q   <= dec_syn_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign pop = rd_valid && rd_ready;

    // Status follows the push stage so it lines up with the count update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_corr_q <= 1'b0;
            overflow_q <= 1'b0;
            err_syn_q  <= '0;
        end else begin
            overflow_q <= dec_vld_q && fifo_full && !pop;
            err_corr_q <= dec_vld_q && dec_corr_q && (!fifo_full || pop);
            if (dec_vld_q) err_syn_q <= dec_syn_q;
        end
    end

    nibble_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dec_vld_q),
        .pop   (pop),
        .din   (dec_data_q),
        .dout  (rd_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_valid      = !fifo_empty;
    assign err_corrected = err_corr_q;
    assign err_syndrome  = err_syn_q;
    assign frame_err     = frame_err_q;
    assign overflow      = overflow_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_uart_hamming_rx_fifo.sv
// Directed bench for uart_hamming_rx_fifo with a nibble scoreboard and pulse counters.
module tb_uart_hamming_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       rx = 1'b1;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [2:0] fifo_count;
    logic       err_corrected;
    logic [2:0] err_syndrome;
    logic       frame_err;
    logic       overflow;
    logic [1:0] state_out;

    int tests = 0;
    int fails = 0;
    int n_corr = 0, n_ferr = 0, n_ovf = 0;
    logic [3:0] sb_q[$];

    uart_hamming_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .rx            (rx),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fifo_count    (fifo_count),
        .err_corrected (err_corrected),
        .err_syndrome  (err_syndrome),
        .frame_err     (frame_err),
        .overflow      (overflow),
        .state_out     (state_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (err_corrected) n_corr++;
            if (frame_err)     n_ferr++;
            if (overflow)      n_ovf++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            tick(CPB);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bits(b, 8);
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200 && !rd_valid; i++) @(negedge clk);
        chk(tag, rd_valid, 1);
    endtask

    task automatic read_one(input string tag);
        logic [3:0] exp;
        wait_valid({tag, "_valid"});
        @(negedge clk);
        exp = sb_q.pop_front();
        chk({tag, "_data"}, rd_data, exp);
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_syn", err_syndrome, 0);
        chk("rst_pulses", {err_corrected, frame_err, overflow}, 0);
        chk("rst_state", state_out, 0);
        rst_n = 1'b1;
        tick(4);

        // Clean frame
        send_byte(8'h55, 1'b1);
        sb_q.push_back(4'hB);
        wait_valid("clean_valid");
        @(negedge clk);
        chk("clean_count", fifo_count, 1);
        chk("clean_syn", err_syndrome, 0);
        chk("clean_pulses", n_corr + n_ferr + n_ovf, 0);
        read_one("clean");
        @(negedge clk);
        chk("clean_empty", rd_valid, 0);

        // Single-bit error at codeword bit 4
        send_byte(8'h45, 1'b1);
        sb_q.push_back(4'hB);
        read_one("sbe");
        chk("sbe_corr", n_corr, 1);
        chk("sbe_syn", err_syndrome, 5);

        // Bad stop bit
        send_byte(8'h55, 1'b0);
        tick(4);
        chk("stop_ferr", n_ferr, 1);
        chk("stop_count", fifo_count, 0);
        chk("stop_syn_kept", err_syndrome, 5);

        // Pad bit set
        send_byte(8'hD5, 1'b1);
        tick(4);
`ifdef UART_RX_SECDED_EN
        sb_q.push_back(4'hB);
        chk("pad_corr", n_corr, 2);
        read_one("pad");
`else
        chk("pad_ferr", n_ferr, 2);
        chk("pad_count", fifo_count, 0);
`endif

        // Back-to-back frames
        send_byte(8'h55, 1'b1);
        sb_q.push_back(4'hB);
        send_byte(8'h5D, 1'b1);   // codeword bit 3 flipped
        sb_q.push_back(4'hB);
        tick(2);
        chk("b2b_count", fifo_count, 2);
        chk("b2b_syn", err_syndrome, 4);
        read_one("b2b0");
        read_one("b2b1");

        // Overflow on the fifth frame
        for (int k = 0; k < 5; k++) begin
            send_byte(8'h55, 1'b1);
            if (k < DEPTH) sb_q.push_back(4'hB);
        end
        tick(4);
        chk("ovf_pulse", n_ovf, 1);
        chk("ovf_count", fifo_count, 4);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", rd_data, sb_q.pop_front());
            rd_ready = 1'b1;
            @(negedge clk);
        end
        chk("drain_empty", rd_valid, 0);
        chk("drain_count", fifo_count, 0);
        rd_ready = 1'b0;

        // False start
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        chk("fs_state", state_out, 0);
        chk("fs_count", fifo_count, 0);
        chk("fs_flags", n_ferr + n_ovf, 2 + 1);

        // Enable drop aborts a frame silently
        send_bits(8'h55, 3);
        chk("ena_mid_state", state_out, 2);
        ena = 1'b0;
        tick(1);
        chk("ena_abort_state", state_out, 0);
        rx = 1'b1;
        ena = 1'b1;
        tick(6 * CPB);
        chk("ena_count", fifo_count, 0);

        // Reset mid-frame with an entry already queued
        send_byte(8'h45, 1'b1);
        tick(4);
        send_bits(8'h55, 3);
        chk("rmf_state", state_out, 2);
        rst_n = 1'b0;
        #2;
        chk("rmf_valid", rd_valid, 0);
        chk("rmf_data", rd_data, 0);
        chk("rmf_count", fifo_count, 0);
        chk("rmf_syn", err_syndrome, 0);
        chk("rmf_state_idle", state_out, 0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        send_byte(8'h55, 1'b1);
        sb_q.push_back(4'hB);
        read_one("post_rst");
        chk("post_rst_syn", err_syndrome, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
